// File: rtl/div3_seq_cnt.sv
// Divide-by-3 sequencer: registered 0->1->2 state with a one-cycle wrap tick
// and a wrapping or saturating tick event counter with a sticky overflow flag.

module div3_comb (
  input  logic [3:0] cnt,
  output logic [3:0] nxt_cnt,
  output logic       three
);
  always_comb begin
    nxt_cnt = 4'd0;
    three   = 1'b0;
    case (cnt)
      4'd0: nxt_cnt = 4'd1;
      4'd1: nxt_cnt = 4'd2;
      4'd2: begin
        nxt_cnt = 4'd0;
        three   = 1'b1;
      end
      default: nxt_cnt = 4'd0;
    endcase
  end
endmodule

module div3_seq_cnt #(
  parameter int TICK_W = 8,
  parameter bit SAT    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [3:0]        cnt,
  output logic              tick,
  output logic [TICK_W-1:0] tick_cnt,
  output logic              ovf
);
  localparam logic [TICK_W-1:0] TICK_MAX = '1;
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  logic [3:0]        cnt_reg;
  logic              tick_reg;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic              ovf_reg;
  logic [3:0]        nxt_cnt;
  logic              three;
  logic              cnt_legal;

  div3_comb u_div3_comb (
    .cnt     (cnt_reg),
    .nxt_cnt (nxt_cnt),
    .three   (three)
  );

  assign cnt_legal = (cnt_reg <= 4'd2);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg      <= 4'd0;
      tick_reg     <= 1'b0;
      tick_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
    end else if (!cnt_legal) begin
      // Upset recovery: return to 0 even with en low, and never count it as a wrap.
      cnt_reg  <= 4'd0;
      tick_reg <= 1'b0;
    end else if (en) begin
      cnt_reg  <= nxt_cnt;
      tick_reg <= three;
      if (three) begin
        if (tick_cnt_reg != TICK_MAX) begin
          tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
        end else begin
          ovf_reg <= 1'b1;
          if (!SAT) tick_cnt_reg <= '0;
        end
      end
    end else begin
      tick_reg <= 1'b0;
    end
  end

  assign cnt      = cnt_reg;
  assign tick     = tick_reg;
  assign tick_cnt = tick_cnt_reg;
  assign ovf      = ovf_reg;
endmodule

// File: tb/tb_div3_seq_cnt.sv
// Directed bench for div3_seq_cnt: an 8-bit wrapping instance plus two 2-bit
// instances (wrapping and saturating) for the counter overflow behaviour.

module tb_div3_seq_cnt;
  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic       rst_s, en_s, clr_s;
  logic [3:0] cnt, cnt_w, cnt_s;
  logic       tick, tick_w, tick_s;
  logic [7:0] tick_cnt;
  logic [1:0] tick_cnt_w, tick_cnt_s;
  logic       ovf, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div3_seq_cnt #(.TICK_W(8), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .cnt(cnt), .tick(tick), .tick_cnt(tick_cnt), .ovf(ovf)
  );

  div3_seq_cnt #(.TICK_W(2), .SAT(1'b0)) dut_w (
    .clk(clk), .rst(rst_s), .en(en_s), .clr(clr_s),
    .cnt(cnt_w), .tick(tick_w), .tick_cnt(tick_cnt_w), .ovf(ovf_w)
  );

  div3_seq_cnt #(.TICK_W(2), .SAT(1'b1)) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .clr(clr_s),
    .cnt(cnt_s), .tick(tick_s), .tick_cnt(tick_cnt_s), .ovf(ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int c, input int t, input int tc, input int o);
    chk({tag, ".cnt"}, 32'(cnt), 32'(c));
    chk({tag, ".tick"}, 32'(tick), 32'(t));
    chk({tag, ".tick_cnt"}, 32'(tick_cnt), 32'(tc));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask

  // Advance one edge; outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    rst_s = 1'b1; en_s = 1'b0; clr_s = 1'b0;
    #1;
    step();
    chk_main("reset", 0, 0, 0, 0);

    // 1: free run, tick on every third edge
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_main($sformatf("run%0d", k), k % 3, (k % 3 == 0) ? 1 : 0, k / 3, 0);
      $display("run step %0d: cnt=%0d tick=%0d tick_cnt=%0d", k, cnt, tick, tick_cnt);
    end

    // 2: en pattern 1,0,0,1,1 from cnt=0
    en = 1'b1; step(); chk_main("en_a", 1, 0, 3, 0);
    en = 1'b0; step(); chk_main("en_b", 1, 0, 3, 0);
    en = 1'b0; step(); chk_main("en_c", 1, 0, 3, 0);
    en = 1'b1; step(); chk_main("en_d", 2, 0, 3, 0);
    en = 1'b1; step(); chk_main("en_e", 0, 1, 4, 0);
    $display("en pattern done: cnt=%0d tick_cnt=%0d", cnt, tick_cnt);

    // 3: illegal state recovery with en low
    en = 1'b0;
    dut.cnt_reg = 4'hB;
    step(); chk_main("seu", 0, 0, 4, 0);
    step(); chk_main("seu_hold", 0, 0, 4, 0);
    $display("seu recovery: cnt=%0d tick=%0d tick_cnt=%0d", cnt, tick, tick_cnt);

    // 5: clr while cnt==2 and en=1
    en = 1'b1;
    step(); chk_main("pre_clr1", 1, 0, 4, 0);
    step(); chk_main("pre_clr2", 2, 0, 4, 0);
    clr = 1'b1;
    step(); chk_main("clr", 0, 0, 0, 0);
    clr = 1'b0;
    $display("clr at wrap: cnt=%0d tick=%0d tick_cnt=%0d", cnt, tick, tick_cnt);

    // 6: rst mid-sequence with tick_cnt=5, cnt=1
    for (int k = 1; k <= 16; k++) step();
    chk_main("pre_rst", 1, 0, 5, 0);
    rst = 1'b1;
    step(); chk_main("rst_mid", 0, 0, 0, 0);
    rst = 1'b0;
    step(); chk_main("restart1", 1, 0, 0, 0);
    step(); chk_main("restart2", 2, 0, 0, 0);
    step(); chk_main("restart3", 0, 1, 1, 0);
    step(); chk_main("restart4", 1, 0, 1, 0);
    $display("restart: cnt=%0d tick=%0d tick_cnt=%0d", cnt, tick, tick_cnt);

    // 4: 2-bit counters, wrap vs saturate over five wraps
    en = 1'b0;
    rst_s = 1'b1;
    step();
    chk("w_reset.tick_cnt", 32'(tick_cnt_w), 32'd0);
    chk("s_reset.ovf", 32'(ovf_s), 32'd0);
    rst_s = 1'b0; en_s = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k % 3 == 0) begin
        chk($sformatf("w_wrap%0d.tick_cnt", k / 3), 32'(tick_cnt_w), 32'((k / 3) % 4));
        chk($sformatf("w_wrap%0d.ovf", k / 3), 32'(ovf_w), (k / 3 >= 4) ? 32'd1 : 32'd0);
        chk($sformatf("s_wrap%0d.tick_cnt", k / 3), 32'(tick_cnt_s), (k / 3 >= 3) ? 32'd3 : 32'(k / 3));
        chk($sformatf("s_wrap%0d.ovf", k / 3), 32'(ovf_s), (k / 3 >= 4) ? 32'd1 : 32'd0);
        chk($sformatf("s_wrap%0d.tick", k / 3), 32'(tick_s), 32'd1);
        $display("wrap %0d: wrap_cnt=%0d wrap_ovf=%0d sat_cnt=%0d sat_ovf=%0d",
                 k / 3, tick_cnt_w, ovf_w, tick_cnt_s, ovf_s);
      end else begin
        chk($sformatf("w_step%0d.tick", k), 32'(tick_w), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
